// File: rtl/logic_pipe.sv
// Two-stage valid/ready pipeline applying one of four bitwise functions to A, B, D,
// with a saturating, clearable count of completed output transfers.
module logic_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic [WIDTH-1:0] D_i,
  input  logic [1:0]       mode_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] E_o,
  input  logic             clr_i,
  output logic [CNT_W-1:0] xfer_cnt_o
);

  localparam int unsigned MODE_W = 2;

  typedef struct packed {
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [WIDTH-1:0]  d;
    logic [MODE_W-1:0] mode;
  } beat_t;

  beat_t            s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] e_q, e_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s2_en_c, s1_en_c;

  // Result of a beat, always using the mode captured with that beat.
  function automatic logic [WIDTH-1:0] apply_fn(input beat_t bt);
    logic [WIDTH-1:0] r;
    r = '0;
    case (bt.mode)
      2'd0: r = (bt.a & bt.b) | bt.d;
      2'd1: r = (bt.a | bt.b) & bt.d;
      2'd2: r = bt.a ^ bt.b ^ bt.d;
      2'd3: r = ~((bt.a & bt.b) | bt.d);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stage enables ripple back from ready_i so a full pipe frees up with no bubble.
  assign s2_en_c = !valid_q || ready_i;
  assign s1_en_c = !s1_valid_q || s2_en_c;

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    e_d        = e_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;

    if (s2_en_c) begin
      valid_d = s1_valid_q;
      if (s1_valid_q) begin
        e_d = apply_fn(s1_q);
      end
    end

    if (s1_en_c) begin
      s1_valid_d = valid_i;
      if (valid_i) begin
        s1_d.a    = A_i;
        s1_d.b    = B_i;
        s1_d.d    = D_i;
        s1_d.mode = mode_i;
      end
    end

    // Clear takes priority over a same-cycle transfer; count saturates at all-ones.
    if (clr_i) begin
      cnt_d = '0;
    end else if (valid_q && ready_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      e_q        <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      e_q        <= e_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ready_o    = s1_en_c;
  assign valid_o    = valid_q;
  assign E_o        = e_q;
  assign xfer_cnt_o = cnt_q;

endmodule

// File: tb/tb_logic_pipe.sv
// Directed bench for logic_pipe: functions, streaming, backpressure, saturation,
// clear priority, 1-bit legacy truth table and mid-stream reset.
module tb_logic_pipe;

  logic clk;
  logic rst_n;

  // u0: WIDTH=8, CNT_W=16
  logic       v0, r0, clr0, ro0, vo0;
  logic [7:0] a0, b0, d0, e0;
  logic [1:0] m0;
  logic [15:0] cnt0;

  // u1: WIDTH=8, CNT_W=2
  logic       v1, r1, clr1, ro1, vo1;
  logic [7:0] a1, b1, d1, e1;
  logic [1:0] m1;
  logic [1:0] cnt1;

  // u2: WIDTH=1, CNT_W=16
  logic       v2, r2, clr2, ro2, vo2;
  logic [0:0] a2, b2, d2, e2;
  logic [1:0] m2;
  logic [15:0] cnt2;

  int passed = 0;
  int total  = 0;

  logic [7:0] fa [4] = '{8'hF0, 8'hF0, 8'hF0, 8'hF0};
  logic [7:0] fb [4] = '{8'hCC, 8'hCC, 8'hCC, 8'hCC};
  logic [7:0] fd [4] = '{8'h01, 8'h0F, 8'h01, 8'h01};
  logic [1:0] fm [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [7:0] fe [4] = '{8'hC1, 8'h0C, 8'h3D, 8'h3E};

  logic [7:0] sa [8] = '{8'h00, 8'hFF, 8'hAA, 8'h12, 8'h0F, 8'h80, 8'hC3, 8'hFF};
  logic [7:0] sb [8] = '{8'h00, 8'h0F, 8'h55, 8'h34, 8'hF0, 8'h80, 8'h3C, 8'hFF};
  logic [7:0] sd [8] = '{8'h00, 8'h00, 8'hF0, 8'h56, 8'h00, 8'h01, 8'h5A, 8'hFF};
  logic [1:0] sm [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
  logic [7:0] se [8] = '{8'h00, 8'h0F, 8'hF0, 8'h70, 8'hFF, 8'h81, 8'h5A, 8'hFF};

  logic [0:0] la [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [0:0] lb [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [0:0] ld [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [0:0] le [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  logic_pipe #(.WIDTH(8), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .valid_i(v0), .ready_o(ro0), .A_i(a0), .B_i(b0), .D_i(d0),
    .mode_i(m0), .valid_o(vo0), .ready_i(r0), .E_o(e0), .clr_i(clr0), .xfer_cnt_o(cnt0)
  );

  logic_pipe #(.WIDTH(8), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .valid_i(v1), .ready_o(ro1), .A_i(a1), .B_i(b1), .D_i(d1),
    .mode_i(m1), .valid_o(vo1), .ready_i(r1), .E_o(e1), .clr_i(clr1), .xfer_cnt_o(cnt1)
  );

  logic_pipe #(.WIDTH(1), .CNT_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .valid_i(v2), .ready_o(ro2), .A_i(a2), .B_i(b2), .D_i(d2),
    .mode_i(m2), .valid_o(vo2), .ready_i(r2), .E_o(e2), .clr_i(clr2), .xfer_cnt_o(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {v0, r0, clr0, a0, b0, d0, m0} = '0;
    {v1, r1, clr1, a1, b1, d1, m1} = '0;
    {v2, r2, clr2, a2, b2, d2, m2} = '0;
    #2;
    chk("rst_valid_o", 64'(vo0), 64'd0);
    chk("rst_E_o", 64'(e0), 64'h00);
    chk("rst_cnt", 64'(cnt0), 64'd0);
    chk("rst_ready_o", 64'(ro0), 64'd1);
    chk("rst_ready_o_u1", 64'(ro1), 64'd1);
    chk("rst_ready_o_u2", 64'(ro2), 64'd1);
    tick();
    rst_n = 1'b1;
    r0 = 1'b1;

    // Four functions, back to back; result of beat i-1 visible after edge i.
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        v0 = 1'b1; a0 = fa[i]; b0 = fb[i]; d0 = fd[i]; m0 = fm[i];
      end else begin
        v0 = 1'b0;
      end
      tick();
      if (i == 0) begin
        chk("fn_latency_valid", 64'(vo0), 64'd0);
      end else begin
        chk("fn_valid", 64'(vo0), 64'd1);
        chk($sformatf("fn_mode%0d", i - 1), 64'(e0), 64'(fe[i-1]));
      end
    end
    tick();
    chk("empty_valid", 64'(vo0), 64'd0);
    chk("empty_E_hold", 64'(e0), 64'h3E);
    chk("fn_cnt", 64'(cnt0), 64'd4);

    // Eight-beat stream at full rate.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        v0 = 1'b1; a0 = sa[i]; b0 = sb[i]; d0 = sd[i]; m0 = sm[i];
      end else begin
        v0 = 1'b0;
      end
      tick();
      if (i > 0) begin
        chk($sformatf("stream_valid%0d", i - 1), 64'(vo0), 64'd1);
        chk($sformatf("stream_E%0d", i - 1), 64'(e0), 64'(se[i-1]));
      end
    end
    tick();
    chk("stream_cnt", 64'(cnt0), 64'd12);

    // Backpressure: two beats fill the pipe, third waits.
    r0 = 1'b0;
    v0 = 1'b1; a0 = 8'hF0; b0 = 8'hCC; d0 = 8'h01; m0 = 2'd3;
    #1;
    chk("bp_ready_empty", 64'(ro0), 64'd1);
    tick();
    a0 = 8'h0F; b0 = 8'h0F; d0 = 8'h33; m0 = 2'd2;
    chk("bp_ready_s1", 64'(ro0), 64'd1);
    tick();
    a0 = 8'h55; b0 = 8'hAA; d0 = 8'hFF; m0 = 2'd1;
    chk("bp_full_ready", 64'(ro0), 64'd0);
    chk("bp_full_valid", 64'(vo0), 64'd1);
    chk("bp_full_E", 64'(e0), 64'h3E);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_hold_E", 64'(e0), 64'h3E);
      chk("bp_hold_ready", 64'(ro0), 64'd0);
      chk("bp_hold_valid", 64'(vo0), 64'd1);
    end
    chk("bp_hold_cnt", 64'(cnt0), 64'd12);
    r0 = 1'b1;
    #1;
    chk("bp_release_ready", 64'(ro0), 64'd1);
    tick();
    v0 = 1'b0;
    chk("bp_out1", 64'(e0), 64'h33);
    chk("bp_out1_valid", 64'(vo0), 64'd1);
    tick();
    chk("bp_out2", 64'(e0), 64'hFF);
    chk("bp_out2_valid", 64'(vo0), 64'd1);
    tick();
    chk("bp_drained", 64'(vo0), 64'd0);
    chk("bp_cnt", 64'(cnt0), 64'd15);

    // Saturation on a 2-bit counter, then clear racing a transfer.
    r1 = 1'b1;
    v1 = 1'b1; a1 = 8'hF0; b1 = 8'hCC; d1 = 8'h01; m1 = 2'd0;
    repeat (5) tick();
    v1 = 1'b0;
    repeat (3) tick();
    chk("sat_cnt", 64'(cnt1), 64'd3);
    chk("sat_E", 64'(e1), 64'hC1);
    v1 = 1'b1; m1 = 2'd3;
    tick();
    v1 = 1'b0;
    tick();
    chk("clr_pre_valid", 64'(vo1), 64'd1);
    chk("clr_pre_E", 64'(e1), 64'h3E);
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    chk("clr_vs_xfer", 64'(cnt1), 64'd0);
    tick();
    chk("clr_hold", 64'(cnt1), 64'd0);

    // Single-bit legacy gate, mode 0.
    r2 = 1'b1; m2 = 2'd0;
    for (int i = 0; i <= 7; i++) begin
      if (i < 7) begin
        v2 = 1'b1; a2 = la[i]; b2 = lb[i]; d2 = ld[i];
      end else begin
        v2 = 1'b0;
      end
      tick();
      if (i > 0) begin
        chk($sformatf("legacy_valid%0d", i - 1), 64'(vo2), 64'd1);
        chk($sformatf("legacy_E%0d", i - 1), 64'(e2), 64'(le[i-1]));
      end
    end
    tick();
    chk("legacy_cnt", 64'(cnt2), 64'd7);
    chk("legacy_ready", 64'(ro2), 64'd1);

    // Reset with two beats in flight.
    r0 = 1'b0;
    v0 = 1'b1; a0 = 8'hF0; b0 = 8'hCC; d0 = 8'h01; m0 = 2'd0;
    tick();
    m0 = 2'd2;
    tick();
    v0 = 1'b0;
    chk("prerst_valid", 64'(vo0), 64'd1);
    chk("prerst_E", 64'(e0), 64'hC1);
    chk("prerst_ready", 64'(ro0), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(vo0), 64'd0);
    chk("midrst_E", 64'(e0), 64'h00);
    chk("midrst_cnt", 64'(cnt0), 64'd0);
    chk("midrst_ready", 64'(ro0), 64'd1);
    tick();
    rst_n = 1'b1;
    r0 = 1'b1;
    repeat (2) tick();
    chk("postrst_valid", 64'(vo0), 64'd0);
    chk("postrst_cnt", 64'(cnt0), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
